// File: rtl/umi_arb_pkg.sv
// Shared encodings and a small index helper for the UMI packet arbiter slice.
package umi_arb_pkg;

   localparam logic [1:0] UMI_ARB_PRIO = 2'b00;
   localparam logic [1:0] UMI_ARB_RR   = 2'b01;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   // Index of the channel after idx, wrapping at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/umi_rr_select.sv
// Rotating priority selector: lowest set request at or after ptr wins (wraps modulo N).
module umi_rr_select
  import umi_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
)
(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          found
);

   logic [2*N-1:0] dbl;
   int             off;
   int             sum;

   // Shifting the doubled vector right by ptr puts the rotated request set in
   // the low half, so the lowest set bit is the offset from ptr to the winner.
   always_comb begin
      dbl   = {req, req} >> ptr;
      found = 1'b0;
      off   = 0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (dbl[i]) begin
            found = 1'b1;
            off   = i;
         end
      end
      sum = (int'(ptr) + off) % N;
      idx = IW'(sum);
      for (int i = 0; i < N; i++) begin
         grant[i] = found && (idx == IW'(i));
      end
   end

endmodule

// File: rtl/umi_packet_arbiter.sv
// Packet-level arbiter: shares one valid/ready channel among N inputs and
// locks the grant from the first presented beat to the handshake of the last beat.
module umi_packet_arbiter
  import umi_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 256,
   localparam int IW = (N > 1) ? $clog2(N) : 1
)
(
   input  logic          clk,
   input  logic          nreset,
   input  logic [1:0]    mode,
   input  logic [N-1:0]  mask,
   input  logic [N-1:0]  in_valid,
   input  logic [N-1:0]  in_last,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]  in_ready,
   output logic          out_valid,
   output logic          out_last,
   output logic [W-1:0]  out_data,
   input  logic          out_ready,
   output logic [IW-1:0] owner,
   output logic          busy
);

   // Handshake: a beat moves when valid & ready are both high on a rising clk;
   // once valid is shown it is held (with data/last stable) until that beat moves,
   // which is why a stalled first beat already locks the grant.

   logic [0:0]    state;
   logic [IW-1:0] owner_q;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] sel_ptr;
   logic [N-1:0]  req;
   logic [N-1:0]  win_grant;
   logic [IW-1:0] win_idx;
   logic          win_found;
   logic [N-1:0]  owner_oh;
   logic [N-1:0]  sel_oh;
   logic [IW-1:0] nxt_win;
   logic [IW-1:0] nxt_owner;

   assign req     = in_valid & ~mask;
   assign sel_ptr = (mode == UMI_ARB_RR) ? rr_ptr : '0;

   umi_rr_select #(.N(N), .IW(IW)) u_select (
      .req   (req),
      .ptr   (sel_ptr),
      .grant (win_grant),
      .idx   (win_idx),
      .found (win_found)
   );

   always_comb begin
      for (int i = 0; i < N; i++) begin
         owner_oh[i] = (owner_q == IW'(i));
      end
      sel_oh    = (state == HOLD) ? owner_oh : win_grant;
      nxt_win   = IW'(wrap_inc(int'(win_idx), N));
      nxt_owner = IW'(wrap_inc(int'(owner_q), N));
   end

   always_comb begin
      out_data = '0;
      for (int i = 0; i < N; i++) begin
         out_data = out_data | (in_data[i*W +: W] & {W{sel_oh[i]}});
      end
      out_valid = nreset & (|(sel_oh & in_valid));
      out_last  = |(sel_oh & in_valid & in_last);
      in_ready  = nreset ? (sel_oh & {N{out_ready}}) : '0;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state   <= IDLE;
         owner_q <= '0;
         rr_ptr  <= '0;
      end else if (state == IDLE) begin
         if (win_found) begin
            owner_q <= win_idx;
            if (out_ready && in_last[win_idx]) begin
               rr_ptr <= nxt_win;
            end else begin
               state <= HOLD;
            end
         end
      end else if (out_valid && out_ready && out_last) begin
         state  <= IDLE;
         rr_ptr <= nxt_owner;
      end
   end

   assign owner = owner_q;
   assign busy  = (state == HOLD);

endmodule

// File: tb/tb_umi_packet_arbiter.sv
// Directed bench for umi_packet_arbiter (N=4, W=16) with immediate-assertion checks.
module tb_umi_packet_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int IW = 2;

   logic          clk;
   logic          nreset;
   logic [1:0]    mode;
   logic [N-1:0]  mask;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_last;
   logic [N*W-1:0] in_data;
   logic [N-1:0]  in_ready;
   logic          out_valid;
   logic          out_last;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic [IW-1:0] owner;
   logic          busy;

   int checks = 0;
   int errors = 0;

   umi_packet_arbiter #(.N(N), .W(W)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .mode      (mode),
      .mask      (mask),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_data  (out_data),
      .out_ready (out_ready),
      .owner     (owner),
      .busy      (busy)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // payload for channel ch, beat b: 0xA<ch><b>
   function automatic logic [W-1:0] dval(input int ch, input int b);
      return W'(32'hA000 + ch * 256 + b);
   endfunction

   task automatic load(input int b);
      for (int ch = 0; ch < N; ch++) in_data[ch*W +: W] = dval(ch, b);
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input int b);
      in_valid = v;
      in_last  = l;
      load(b);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      nreset    = 1'b0;
      mode      = 2'b00;
      mask      = '0;
      out_ready = 1'b1;
      drive(4'b1111, 4'b1111, 0);

      // reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_owner",     32'(owner),     32'd0);
      tick();
      tick();
      nreset = 1'b1;

      // fixed priority: channel 1 wins every cycle, channel 3 starves
      for (int k = 0; k < 3; k++) begin
         drive(4'b1010, 4'b1111, k);
         chk("prio_in_ready", 32'(in_ready), 32'b0010);
         chk("prio_data",     32'(out_data), 32'(dval(1, k)));
         tick();
      end
      chk("prio_owner", 32'(owner), 32'd1);
      chk("prio_busy",  32'(busy),  32'd0);

      // packet lock: ch2 sends 3 beats, ch0 raises valid on beat 2
      drive(4'b0100, 4'b0000, 0);
      chk("lock_b1_ready", 32'(in_ready), 32'b0100);
      chk("lock_b1_busy",  32'(busy),     32'd0);
      tick();
      drive(4'b0101, 4'b0000, 1);
      chk("lock_b2_ready", 32'(in_ready), 32'b0100);
      chk("lock_b2_data",  32'(out_data), 32'(dval(2, 1)));
      chk("lock_b2_owner", 32'(owner),    32'd2);
      chk("lock_b2_busy",  32'(busy),     32'd1);
      tick();
      drive(4'b0001, 4'b0000, 2);
      chk("lock_bubble_valid", 32'(out_valid), 32'd0);
      chk("lock_bubble_busy",  32'(busy),      32'd1);
      tick();
      drive(4'b0101, 4'b0100, 3);
      chk("lock_b3_ready", 32'(in_ready), 32'b0100);
      chk("lock_b3_last",  32'(out_last), 32'd1);
      chk("lock_b3_data",  32'(out_data), 32'(dval(2, 3)));
      tick();
      drive(4'b0001, 4'b0001, 4);
      chk("lock_after_ready", 32'(in_ready), 32'b0001);
      chk("lock_after_busy",  32'(busy),     32'd0);
      chk("lock_after_data",  32'(out_data), 32'(dval(0, 4)));
      tick();

      // stall lock: ch1 wins while stalled, ch0 arrives and must wait
      out_ready = 1'b0;
      drive(4'b0010, 4'b0010, 0);
      chk("stall_ready0", 32'(in_ready),  32'd0);
      chk("stall_valid0", 32'(out_valid), 32'd1);
      tick();
      for (int k = 1; k < 5; k++) begin
         drive(4'b0011, 4'b0011, 0);
         chk("stall_data",  32'(out_data), 32'(dval(1, 0)));
         chk("stall_owner", 32'(owner),    32'd1);
         chk("stall_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      drive(4'b0011, 4'b0011, 0);
      chk("stall_xfer_ready", 32'(in_ready), 32'b0010);
      chk("stall_xfer_data",  32'(out_data), 32'(dval(1, 0)));
      tick();
      drive(4'b0001, 4'b0001, 1);
      chk("stall_next_ready", 32'(in_ready), 32'b0001);
      tick();

      // mask: ch0 packet finishes despite mask, then ch0 excluded
      drive(4'b0001, 4'b0000, 0);
      chk("mask_b1_ready", 32'(in_ready), 32'b0001);
      tick();
      mask = 4'b0001;
      drive(4'b0011, 4'b0000, 1);
      chk("mask_b2_ready", 32'(in_ready), 32'b0001);
      tick();
      drive(4'b0011, 4'b0001, 2);
      chk("mask_b3_ready", 32'(in_ready), 32'b0001);
      chk("mask_b3_last",  32'(out_last), 32'd1);
      tick();
      drive(4'b0011, 4'b0011, 3);
      chk("mask_excl_ready", 32'(in_ready), 32'b0010);
      tick();
      drive(4'b0001, 4'b0001, 4);
      chk("mask_only0_valid", 32'(out_valid), 32'd0);
      chk("mask_only0_ready", 32'(in_ready),  32'd0);
      tick();
      mask = 4'b0000;
      drive(4'b0001, 4'b0001, 5);
      chk("mask_clear_ready", 32'(in_ready), 32'b0001);
      tick();

      // reserved mode behaves as fixed priority even with rr_ptr nonzero
      mode = 2'b10;
      drive(4'b1111, 4'b1111, 0);
      chk("mode10_ready", 32'(in_ready), 32'b0001);
      tick();

      // reset mid-packet
      mode = 2'b00;
      drive(4'b1000, 4'b0000, 0);
      tick();
      chk("rstmid_busy",  32'(busy),  32'd1);
      chk("rstmid_owner", 32'(owner), 32'd3);
      nreset = 1'b0;
      #1;
      chk("rstmid_out_valid", 32'(out_valid), 32'd0);
      chk("rstmid_in_ready",  32'(in_ready),  32'd0);
      chk("rstmid_busy0",     32'(busy),      32'd0);
      chk("rstmid_owner0",    32'(owner),     32'd0);
      tick();
      nreset = 1'b1;

      // round-robin from rr_ptr 0: 0,1,2,3,0
      mode = 2'b01;
      for (int k = 0; k < 5; k++) begin
         drive(4'b1111, 4'b1111, k);
         chk("rr_ready", 32'(in_ready), 32'(1 << (k % 4)));
         chk("rr_data",  32'(out_data), 32'(dval(k % 4, k)));
         tick();
         chk("rr_owner", 32'(owner), 32'(k % 4));
      end

      in_valid = '0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/umi_packet_arbiter.md
# umi_packet_arbiter

Packet-level arbiter that shares one UMI-style valid/ready output channel among N requesting input channels. Selects a winner by fixed priority or round-robin and locks the grant from the first presented beat until the handshake of the beat flagged last. It sits in front of shared UMI resources (crossbar outputs, shared endpoints), where per-cycle arbitration would interleave multi-beat transactions.

## Interface
Parameters:
- N, 4, number of input channels (N ≥ 1)
- W, 256, payload width per channel (cmd/dst/src/data packed by caller)

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- mode  input  2  arbitration mode: 00 fixed priority (index 0 highest), 01 round-robin, 1x reserved (behaves as 00)
- mask  input  N  1 = channel excluded from new arbitration
- in_valid  input  N  per-channel beat valid
- in_last  input  N  per-channel end-of-packet flag, qualified by in_valid
- in_data  input  N*W  per-channel payload, channel i at [i*W +: W]
- in_ready  output  N  per-channel ready; only the owner's bit can be 1
- out_valid  output  1  merged beat valid
- out_last  output  1  merged end-of-packet flag
- out_data  output  W  merged payload
- out_ready  input  1  downstream ready
- owner  output  log2(N) (min 1)  index of the current or most recent grantee
- busy  output  1  1 while in HOLD state

## Operation
- Eligible requests: req = in_valid & ~mask.
- States: IDLE, HOLD.
- IDLE: combinational selection among req.
  - Mode 00: lowest index wins.
  - Mode 01: search starts at rr_ptr and wraps modulo N; first set bit wins.
  - Winner g drives out_* = in_*[g] and in_ready[g] = out_ready. All other in_ready bits are 0.
  - No eligible request: out_valid = 0, in_ready = 0, owner unchanged.
- IDLE transitions, when a winner g exists:
  - out_ready & in_last[g]: single-beat packet completes; stay IDLE; rr_ptr <= (g+1) mod N; owner <= g.
  - Otherwise (stalled, or multi-beat): go to HOLD with owner <= g. Locking on a stall keeps out_data/out_valid stable per valid/ready rules.
- HOLD:
  - Mux is fixed to owner; mask, mode and other requests are ignored.
  - On out_valid & out_ready & out_last: go to IDLE and set rr_ptr <= (owner+1) mod N.
  - If in_valid[owner] drops (source bubble), out_valid = 0 and HOLD persists.
- rr_ptr advances only on packet completion, never on stalls. In mode 00 it still updates but does not affect selection.
- A mode change takes effect at the next IDLE arbitration.
- N = 1: rr_ptr and owner are constant 0; packet locking still applies.

## Timing
- Zero-cycle latency: in_* to out_* and out_ready to in_ready are combinational; there is no data storage.
- Registered state: state, owner, rr_ptr.
- Reset values:
  - state IDLE, owner 0, rr_ptr 0, busy 0.
  - While nreset is low, out_valid and all in_ready are forced to 0.
- Asserting reset mid-packet aborts the lock immediately. The partial packet is the responsibility of the source and sink.
- Back-to-back packets: a packet ending at cycle t frees arbitration at t+1. Nothing is granted in the same cycle as the last handshake.
- Invariants:
  - in_ready is onehot0.
  - out_valid implies that in_valid[selected] is set.
  - owner is stable throughout HOLD.

## Structure
- Shared package umi_arb_pkg holds:
  - mode encodings: UMI_ARB_PRIO = 2'b00, UMI_ARB_RR = 2'b01
  - state encodings: IDLE = 1'b0, HOLD = 1'b1
- Sub-module umi_rr_select (N): takes requests and a pointer, returns a onehot grant plus the winner index. Implemented with the double-width rotate and priority encode technique. With pointer 0 it equals fixed priority, so mode 00 forces ptr = 0.
- The top level holds the FSM, the pointer/owner registers and the W-wide onehot AND-OR mux.

## Test plan
- Fixed priority: mode 00, in_valid = 4'b1010, all single-beat, out_ready = 1 → channel 1 granted every cycle; channel 3 starves.
- Round-robin: mode 01, all four channels valid continuously with single-beat packets → owner sequence 0,1,2,3,0…; each in_ready pulses one cycle in four.
- Packet lock: channel 2 sends 3 beats (last on beat 3) while channel 0 raises valid at beat 2 → channel 0 blocked until the cycle after beat 3; out_data never interleaves.
- Stall lock: winner channel 1 with out_ready = 0 for 5 cycles, higher-priority channel 0 asserts meanwhile → out_data stays channel 1's payload and owner stays 1; the beat transfers when out_ready rises.
- Mask: mask = 4'b0001 during a channel 0 packet → packet completes; channel 0 is then excluded until mask clears.
- Reset mid-packet: assert nreset low during HOLD → out_valid = 0 and in_ready = 0 immediately; after release busy = 0 and rr_ptr = 0.
